// File: rtl/intersection_ctrl.sv
// Two-way intersection sequencer: NS main road rests on green, EW vehicle and
// pedestrian requests are latched and served through yellow and all-red
// clearance phases. All lamp outputs are decoded from registered state only.
// Every duration parameter must lie in 1..2^TW-1.
module intersection_ctrl #(
  parameter int NS_GREEN_MIN_T = 10,
  parameter int EW_GREEN_T     = 10,
  parameter int YELLOW_T       = 4,
  parameter int CLEAR_T        = 2,
  parameter int WALK_T         = 8,
  parameter int TW             = 8
) (
  input  logic       clk,
  input  logic       rst,        // asynchronous, active-low
  input  logic       ew_car_req,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_NS_GO   = 3'd0,
    S_NS_YLW  = 3'd1,
    S_CLR_A   = 3'd2,
    S_EW_GO   = 3'd3,
    S_EW_YLW  = 3'd4,
    S_CLR_B   = 3'd5,
    S_WALK    = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  // Timer reload values: a state lasts exactly its duration because the
  // timer is loaded with duration-1 on entry and the exit happens at zero.
  localparam logic [TW-1:0] L_NS_GO  = TW'(NS_GREEN_MIN_T - 1);
  localparam logic [TW-1:0] L_EW_GO  = TW'(EW_GREEN_T - 1);
  localparam logic [TW-1:0] L_YELLOW = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] L_CLEAR  = TW'(CLEAR_T - 1);
  localparam logic [TW-1:0] L_WALK   = TW'(WALK_T - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;
  logic            r_ew_pend;
  logic            r_ped_pend;
  logic            w_enter_ew;
  logic            w_enter_walk;

  function automatic logic [TW-1:0] dur_m1(input state_t s);
    logic [TW-1:0] d;
    case (s)
      S_NS_GO:            d = L_NS_GO;
      S_NS_YLW, S_EW_YLW: d = L_YELLOW;
      S_CLR_A, S_CLR_B:   d = L_CLEAR;
      S_EW_GO:            d = L_EW_GO;
      S_WALK:             d = L_WALK;
      default:            d = L_NS_GO;
    endcase
    return d;
  endfunction

  // Next-state and timer: transitions are only taken when the timer has
  // expired; the illegal encoding recovers to NS green immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = (r_timer != '0) ? (r_timer - TW'(1)) : '0;
    if (r_state == S_ILLEGAL) begin
      w_state_nxt = S_NS_GO;
    end else if (r_timer == '0) begin
      case (r_state)
        S_NS_GO:  if (r_ew_pend || r_ped_pend) w_state_nxt = S_NS_YLW;
        S_NS_YLW: w_state_nxt = S_CLR_A;
        S_CLR_A:  w_state_nxt = r_ped_pend ? S_WALK : S_EW_GO;
        S_EW_GO:  w_state_nxt = S_EW_YLW;
        S_EW_YLW: w_state_nxt = S_CLR_B;
        S_CLR_B:  w_state_nxt = r_ped_pend ? S_WALK : S_NS_GO;
        // WALK always returns to NS so a waiting EW car cannot starve NS.
        S_WALK:   w_state_nxt = S_NS_GO;
        default:  w_state_nxt = S_NS_GO;
      endcase
    end
    if (w_state_nxt != r_state) begin
      w_timer_nxt = dur_m1(w_state_nxt);
    end
  end

  assign w_enter_ew   = (w_state_nxt == S_EW_GO) && (r_state != S_EW_GO);
  assign w_enter_walk = (w_state_nxt == S_WALK)  && (r_state != S_WALK);

  // State and timer registers; reset aborts any phase back to NS green.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_NS_GO;
      r_timer <= L_NS_GO;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Sticky request latches; a new request on the serving edge wins over the
  // clear, so a request made during its own phase is served next time round.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ew_pend  <= 1'b0;
      r_ped_pend <= 1'b0;
    end else begin
      r_ew_pend  <= ew_car_req | (r_ew_pend  & ~w_enter_ew);
      r_ped_pend <= ped_req    | (r_ped_pend & ~w_enter_walk);
    end
  end

  // Moore lamp decode from the state register only.
  assign ns_green  = (r_state == S_NS_GO);
  assign ns_yellow = (r_state == S_NS_YLW);
  assign ns_red    = !(ns_green || ns_yellow);
  assign ew_green  = (r_state == S_EW_GO);
  assign ew_yellow = (r_state == S_EW_YLW);
  assign ew_red    = !(ew_green || ew_yellow);
  assign walk      = (r_state == S_WALK);
  assign phase     = r_state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl with short phase durations.
// Cycle k is the clock period ending at the k-th rising edge after reset
// release; inputs are driven and outputs sampled on the falling edge.
module tb_intersection_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ew_car_req;
  logic       ped_req;
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic       walk;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  intersection_ctrl #(
    .NS_GREEN_MIN_T(3),
    .EW_GREEN_T    (3),
    .YELLOW_T      (2),
    .CLEAR_T       (1),
    .WALK_T        (2),
    .TW            (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ew_car_req(ew_car_req),
    .ped_req   (ped_req),
    .ns_red    (ns_red),
    .ns_yellow (ns_yellow),
    .ns_green  (ns_green),
    .ew_red    (ew_red),
    .ew_yellow (ew_yellow),
    .ew_green  (ew_green),
    .walk      (walk),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  // Observed lamps packed as {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
  logic [6:0] obs;
  assign obs = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};

  // Reference lamp pattern for each phase number
  function automatic logic [6:0] lamps(input int ph);
    case (ph)
      0:       return 7'b001_100_0;
      1:       return 7'b010_100_0;
      2:       return 7'b100_100_0;
      3:       return 7'b100_001_0;
      4:       return 7'b100_010_0;
      5:       return 7'b100_100_0;
      6:       return 7'b100_100_1;
      default: return 7'b000_000_0;
    endcase
  endfunction

  // Safety invariants, every cycle while out of reset
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      checks++;
      if ((ns_green && ew_green) ||
          (walk && (ns_green || ns_yellow || ew_green || ew_yellow)) ||
          ($countones({ns_red, ns_yellow, ns_green}) != 1) ||
          ($countones({ew_red, ew_yellow, ew_green}) != 1)) begin
        errors++;
        $display("FAIL safety t=%0t: lamps=%b phase=%0d, required exclusive lamps", $time, obs, phase);
      end
    end
  end

  // Hold reset for a cycle and release on a falling edge: cycle 0 begins
  task automatic start_run();
    @(negedge clk);
    rst = 1'b0;
    ew_car_req = 1'b0;
    ped_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    ew_car_req = 1'b0;
    ped_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd0 || obs !== 7'b001_100_0) begin
      errors++;
      $display("FAIL reset_immediate: phase=%0d lamps=%b, required phase=0 lamps=0011000", phase, obs);
    end
    // Requests during reset must be ignored
    ew_car_req = 1'b1;
    ped_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (phase !== 3'd0 || obs !== 7'b001_100_0) begin
      errors++;
      $display("FAIL reset_hold: phase=%0d lamps=%b, required phase=0 lamps=0011000", phase, obs);
    end
    ew_car_req = 1'b0;
    ped_req = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (phase !== 3'd0 || obs !== 7'b001_100_0) begin
        errors++;
        $display("FAIL reset_release cycle %0d: phase=%0d lamps=%b, required phase=0", c, phase, obs);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_idle();
    start_run();
    for (int c = 0; c < 50; c++) begin
      checks++;
      if (phase !== 3'd0 || obs !== 7'b001_100_0) begin
        errors++;
        $display("FAIL idle cycle %0d: phase=%0d lamps=%b, required phase=0 lamps=0011000", c, phase, obs);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ew_only();
    int exp [20] = '{0,0,0,1,1,2,3,3,3,4,4,5,0,0,0,0,0,0,0,0};
    start_run();
    for (int c = 0; c < 20; c++) begin
      ew_car_req = (c == 0);
      checks++;
      if (phase !== 3'(exp[c]) || obs !== lamps(exp[c])) begin
        errors++;
        $display("FAIL ew_only cycle %0d: phase=%0d lamps=%b, required phase=%0d lamps=%b",
                 c, phase, obs, exp[c], lamps(exp[c]));
      end
      @(negedge clk);
    end
    ew_car_req = 1'b0;
  endtask

  task automatic test_ped_only();
    int exp [20] = '{0,0,0,1,1,2,6,6,0,0,0,0,0,0,0,0,0,0,0,0};
    start_run();
    for (int c = 0; c < 20; c++) begin
      ped_req = (c == 0);
      checks++;
      if (phase !== 3'(exp[c]) || obs !== lamps(exp[c])) begin
        errors++;
        $display("FAIL ped_only cycle %0d: phase=%0d lamps=%b, required phase=%0d lamps=%b",
                 c, phase, obs, exp[c], lamps(exp[c]));
      end
      @(negedge clk);
    end
    ped_req = 1'b0;
  endtask

  task automatic test_both();
    int exp [24] = '{0,0,0,1,1,2,6,6,0,0,0,1,1,2,3,3,3,4,4,5,0,0,0,0};
    start_run();
    for (int c = 0; c < 24; c++) begin
      ew_car_req = (c == 0);
      ped_req = (c == 0);
      checks++;
      if (phase !== 3'(exp[c]) || obs !== lamps(exp[c])) begin
        errors++;
        $display("FAIL both cycle %0d: phase=%0d lamps=%b, required phase=%0d lamps=%b",
                 c, phase, obs, exp[c], lamps(exp[c]));
      end
      @(negedge clk);
    end
    ew_car_req = 1'b0;
    ped_req = 1'b0;
  endtask

  task automatic test_rerequest();
    int exp [22] = '{0,0,0,1,1,2,6,6,0,0,0,1,1,2,6,6,0,0,0,0,0,0};
    start_run();
    for (int c = 0; c < 22; c++) begin
      ped_req = (c == 0) || (c == 6);
      checks++;
      if (phase !== 3'(exp[c]) || obs !== lamps(exp[c])) begin
        errors++;
        $display("FAIL rerequest cycle %0d: phase=%0d lamps=%b, required phase=%0d lamps=%b",
                 c, phase, obs, exp[c], lamps(exp[c]));
      end
      @(negedge clk);
    end
    ped_req = 1'b0;
  endtask

  // Held EW request: re-latched on the EW_GO entry edge, served again after
  // the NS minimum green.
  task automatic test_back_to_back();
    int exp [20] = '{0,0,0,1,1,2,3,3,3,4,4,5,0,0,0,1,1,2,3,3};
    start_run();
    ew_car_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (phase !== 3'(exp[c]) || obs !== lamps(exp[c])) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: phase=%0d lamps=%b, required phase=%0d lamps=%b",
                 c, phase, obs, exp[c], lamps(exp[c]));
      end
      @(negedge clk);
    end
    ew_car_req = 1'b0;
  endtask

  task automatic test_async_reset();
    // Part 1: abort EW green without a clock edge
    start_run();
    for (int c = 0; c < 7; c++) begin
      ew_car_req = (c == 0);
      @(negedge clk);
    end
    ew_car_req = 1'b0;
    checks++;
    if (phase !== 3'd3 || obs !== 7'b100_001_0) begin
      errors++;
      $display("FAIL async_pre cycle 7: phase=%0d lamps=%b, required phase=3 lamps=1000010", phase, obs);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd0 || obs !== 7'b001_100_0) begin
      errors++;
      $display("FAIL async_abort: phase=%0d lamps=%b, required phase=0 lamps=0011000", phase, obs);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (phase !== 3'd0) begin
        errors++;
        $display("FAIL async_after_abort cycle %0d: phase=%0d, required 0", c, phase);
      end
      @(negedge clk);
    end
    // Part 2: a latched but unserved EW request is dropped by reset
    start_run();
    ew_car_req = 1'b1;
    @(negedge clk);
    ew_car_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (phase !== 3'd0) begin
        errors++;
        $display("FAIL async_drop_pending cycle %0d: phase=%0d, required 0", c, phase);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0;
    ew_car_req = 1'b0;
    ped_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_idle();
    test_ew_only();
    test_ped_only();
    test_both();
    test_rerequest();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intersection_ctrl.md
Name: intersection_ctrl

Overview:
- Sequences a two-way intersection: north-south (NS) main road, east-west (EW) side road, and one pedestrian crossing.
- NS rests on green. EW vehicle sensor and pedestrian button requests are latched, then served through yellow and all-red clearance phases.
- Sits above the per-direction lamp drivers. All lamp and walk outputs are Moore-decoded from registered state.

Parameters:
- NS_GREEN_MIN_T, 10, minimum NS green cycles before a request may end it
- EW_GREEN_T, 10, fixed EW green cycles
- YELLOW_T, 4, yellow cycles (both directions)
- CLEAR_T, 2, all-red clearance cycles
- WALK_T, 8, pedestrian walk cycles (all vehicle lamps red)
- TW, 8, timer width; every duration parameter must be in 1..2^TW-1

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- ew_car_req  in  1  EW vehicle sensor; level or pulse
- ped_req  in  1  pedestrian button; pulse or level
- ns_red / ns_yellow / ns_green  out  1 each  NS lamps
- ew_red / ew_yellow / ew_green  out  1 each  EW lamps
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state encoding, for debug/status

Behaviour:
- States and encodings:
  - NS_GO=0, NS_YLW=1, CLR_A=2, EW_GO=3, EW_YLW=4, CLR_B=5, WALK=6
  - 7 is illegal: next cycle goes to NS_GO, timer loaded with NS_GREEN_MIN_T-1.
- Reset (rst=0, asynchronous, takes effect immediately):
  - state=NS_GO, timer=NS_GREEN_MIN_T-1, ew_pending=0, ped_pending=0.
  - Outputs: ns_green=1, ew_red=1, all other lamps 0, walk=0, phase=0.
  - A reset asserted mid-phase aborts the phase and drops all pending requests.
- Timer:
  - Decrements by 1 each cycle while >0.
  - On any state transition it loads (duration of new state)-1.
  - Every state therefore lasts exactly its duration in cycles. NS_GO is the exception: it holds at timer=0 indefinitely when nothing is pending.
- Transitions (evaluated at timer==0 only):
  - NS_GO -> NS_YLW if ew_pending | ped_pending; otherwise stay.
  - NS_YLW -> CLR_A.
  - CLR_A -> WALK if ped_pending; else EW_GO.
  - EW_GO -> EW_YLW.
  - EW_YLW -> CLR_B.
  - CLR_B -> WALK if ped_pending; else NS_GO.
  - WALK -> NS_GO, always. A still-pending EW request is served after the next NS minimum green, so NS cannot be starved.
- Pending latches (sticky registers, sampled each clock):
  - ew_pending: set by ew_car_req; cleared on the clock that enters EW_GO.
  - ped_pending: set by ped_req; cleared on the clock that enters WALK.
  - Set wins over clear in the same cycle: a request on the entry edge stays pending for the next cycle.
  - A request that arrives while its phase is active is therefore served in a later cycle.
- Output decode:
  - ns_green: NS_GO. ns_yellow: NS_YLW. ns_red: every other state.
  - ew_green: EW_GO. ew_yellow: EW_YLW. ew_red: every other state.
  - walk: WALK only.
- Safety invariants:
  - Never both greens at once.
  - Never walk together with any green or yellow.
  - Exactly one lamp per direction is on in every cycle.
- No combinational path from inputs to outputs. An input change first affects outputs 1 cycle later at the earliest.

Test Plan (params: NS_GREEN_MIN_T=3, EW_GREEN_T=3, YELLOW_T=2, CLEAR_T=1, WALK_T=2; cycle 0 = first clock after rst deasserts):
- Idle: no requests for 50 cycles -> ns_green=1, ew_red=1, walk=0 throughout; phase stays 0.
- EW only: ew_car_req=1 for cycle 0 only -> NS_GO cycles 0-2, NS_YLW 3-4, CLR_A 5, EW_GO 6-8 (ew_green=1), EW_YLW 9-10, CLR_B 11, NS_GO from 12 and resting.
- Ped only: ped_req pulse at cycle 0 -> NS_YLW 3-4, CLR_A 5, WALK 6-7 (walk=1, ns_red=ew_red=1), NS_GO from 8 and resting; ped_pending=0 after cycle 6.
- Both: ew_car_req and ped_req pulsed at cycle 0 -> WALK 6-7, NS_GO 8-10, NS_YLW 11-12, CLR_A 13, EW_GO 14-16.
- Re-request: ped_req pulsed again during WALK (cycle 6) -> WALK, NS_GO 8-10, NS_YLW, CLR_A, WALK again at 14-15.
- Async reset: assert rst=0 mid EW_GO without a clock edge -> ns_green=1, ew_red=1, walk=0 immediately. After release, no EW service occurs without a new request. Safety invariants checked by assertion on every cycle of all tests.
